// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: opcodes and FSM state encodings shared by the JK bank controller
package jk_seq_pkg;
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INV  = 3'd3;
    localparam logic [2:0] OP_UP   = 3'd4;
    localparam logic [2:0] OP_DOWN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop (00 hold, 01 reset, 10 set, 11 toggle), async active-low clear
module jk_cell (
    input  logic Cp,
    input  logic R,
    input  logic J,
    input  logic K,
    output logic Q
);
    always_ff @(posedge Cp or negedge R)
        if (!R) Q <= 1'b0;
        else    Q <= (J && K) ? ~Q : J ? 1'b1 : K ? 1'b0 : Q;
endmodule

// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: command FSM sequencing a bank of W JK flip-flops as register or up/down counter.
// Define JK_SEQ_WRAP_EN for wrapping counts; otherwise counts saturate at all-ones / zero.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int W = 4,
    parameter int S = 8
) (
    input  logic         Cp,
    input  logic         R,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [S-1:0] cmd_steps,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         done
);
    state_t       r_state;
    logic [2:0]   r_op;
    logic [W-1:0] r_data;
    logic [S-1:0] r_steps;
    logic         w_count;
    logic         w_sat;
    logic [W-1:0] w_up_t;
    logic [W-1:0] w_dn_t;
    logic [W-1:0] w_j;
    logic [W-1:0] w_k;

    assign w_count   = (r_op == OP_UP) || (r_op == OP_DOWN);
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    always_ff @(posedge Cp or negedge R)
        if (!R) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_steps <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    r_op    <= cmd_op;
                    r_data  <= cmd_data;
                    r_steps <= cmd_steps;
                    r_state <= ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_steps == '0) ? ST_DONE : ST_EXEC;
                end
                ST_EXEC: begin
                    r_steps <= r_steps - S'(1);
                    r_state <= (!w_count || r_steps == S'(1)) ? ST_DONE : ST_EXEC;
                end
                default: r_state <= ST_IDLE;
            endcase
        end

    // Toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        w_up_t    = '0;
        w_dn_t    = '0;
        w_up_t[0] = 1'b1;
        w_dn_t[0] = 1'b1;
        for (int i = 1; i < W; i++) begin
            w_up_t[i] = w_up_t[i-1] & Q[i-1];
            w_dn_t[i] = w_dn_t[i-1] & ~Q[i-1];
        end
    end

`ifdef JK_SEQ_WRAP_EN
    assign w_sat = 1'b0;
`else
    assign w_sat = (r_op == OP_UP) ? (&Q) : (r_op == OP_DOWN) ? ~(|Q) : 1'b0;
`endif

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_EXEC && !w_sat) begin
            w_j = (r_op == OP_LOAD || r_op == OP_INV) ? r_data :
                  (r_op == OP_UP) ? w_up_t : (r_op == OP_DOWN) ? w_dn_t : '0;
            w_k = (r_op == OP_CLR) ? '1 : (r_op == OP_LOAD) ? ~r_data : (r_op == OP_INV) ? r_data :
                  (r_op == OP_UP) ? w_up_t : (r_op == OP_DOWN) ? w_dn_t : '0;
        end
    end

    for (genvar g = 0; g < W; g++) begin : g_bank
        jk_cell u_cell (.Cp(Cp), .R(R), .J(w_j[g]), .K(w_k[g]), .Q(Q[g]));
    end
endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb_jk_seq_ctrl: directed and randomized checks of jk_seq_ctrl against an arithmetic model
module tb_jk_seq_ctrl;
    logic       Cp = 1'b0;
    logic       R = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [7:0] cmd_steps = 8'd0;
    logic [3:0] Q;
    logic       busy;
    logic       done;
    int         checks = 0;
    int         errors = 0;
    int         mq = 0;

    jk_seq_ctrl #(.W(4), .S(8)) dut (
        .Cp(Cp), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
        .Q(Q), .busy(busy), .done(done)
    );

    always #5 Cp = ~Cp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_step(input int op, input int q, input int d);
`ifdef JK_SEQ_WRAP_EN
        bit wrap = 1'b1;
`else
        bit wrap = 1'b0;
`endif
        case (op)
            1: return 0;
            2: return d;
            3: return q ^ d;
            4: return wrap ? (q + 1) % 16 : (q < 15 ? q + 1 : 15);
            5: return wrap ? (q + 15) % 16 : (q > 0 ? q - 1 : 0);
            default: return q;
        endcase
    endfunction

    // Called on a negedge with the controller idle; returns on a negedge with it idle again
    task automatic do_cmd(input int op, input int data, input int steps, input bit hold);
        int n;
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = 4'(data);
        cmd_steps = 8'(steps);
        @(negedge Cp);
        if (!hold) cmd_valid = 1'b0;
        else cmd_data = ~cmd_data;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", cmd_ready, 0);
        if ((op == 4 || op == 5) && steps == 0) begin
            chk("done_zero_steps", done, 1);
            chk("q_zero_steps", Q, mq);
        end else begin
            chk("done_early", done, 0);
            n = (op == 4 || op == 5) ? steps : 1;
            for (int k = 1; k <= n; k++) begin
                @(negedge Cp);
                mq = model_step(op, mq, data);
                chk($sformatf("q_op%0d_step%0d", op, k), Q, mq);
                chk($sformatf("done_op%0d_step%0d", op, k), done, k == n);
            end
        end
        cmd_valid = 1'b0;
        @(negedge Cp);
        chk("done_cleared", done, 0);
        chk("ready_again", cmd_ready, 1);
        chk("busy_cleared", busy, 0);
        chk("q_after_done", Q, mq);
    endtask

    initial begin
        #2;
        chk("rst_q", Q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge Cp);
        R = 1'b1;
        repeat (3) @(negedge Cp);
        chk("idle_q", Q, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_ready", cmd_ready, 1);

        do_cmd(2, 4'b1010, 0, 1'b1);
        chk("load_1010", Q, 4'b1010);
        do_cmd(3, 4'b0110, 0, 1'b1);
        chk("inv_0110", Q, 4'b1100);

        do_cmd(2, 4'hD, 0, 1'b0);
        do_cmd(4, 0, 5, 1'b0);
        do_cmd(2, 4'h2, 0, 1'b0);
        do_cmd(5, 0, 4, 1'b1);
        do_cmd(2, 4'h7, 0, 1'b0);
        do_cmd(4, 0, 0, 1'b0);
        chk("up0_hold", Q, 4'h7);
        do_cmd(7, 4'hF, 9, 1'b0);
        chk("op7_nop", Q, 4'h7);
        do_cmd(1, 0, 0, 1'b0);
        do_cmd(5, 0, 3, 1'b0);
        do_cmd(2, 4'hE, 0, 1'b0);
        do_cmd(4, 0, 3, 1'b0);

        // Reset in the middle of a count aborts it with no done pulse
        do_cmd(2, 4'h3, 0, 1'b0);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_steps = 8'd10;
        @(negedge Cp);
        cmd_valid = 1'b0;
        @(negedge Cp);
        chk("abort_step1", Q, 4'h4);
        @(negedge Cp);
        chk("abort_step2", Q, 4'h5);
        R = 1'b0;
        #1;
        mq = 0;
        chk("abort_q", Q, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", cmd_ready, 1);
        @(negedge Cp);
        chk("abort_no_done", done, 0);
        R = 1'b1;
        @(negedge Cp);
        do_cmd(2, 4'h9, 0, 1'b0);
        do_cmd(1, 0, 0, 1'b0);
        chk("clr_after_abort", Q, 0);

        for (int t = 0; t < 40; t++)
            do_cmd($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 6), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
